uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 68 ++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: character FIFO between a bus-side writer and a UART transmitter
// Ports: clk, rst (async, active-high), flush (sync discard);
//   in_data/in_valid/in_ready  write side, ready = !full && !flush;
//   out_data/out_valid/out_ready  head character to the transmitter;
//   level, empty, full, almost_full  occupancy status (all pointer-derived).
// Optional macro UART_TX_FIFO_BYPASS_EN: when empty and the transmitter is ready,
//   in_data is forwarded combinationally without touching the pointers.
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 16,
  parameter int AF_LEVEL  = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_BITS-1:0]       in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [DATA_BITS-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_en, rd_en;
  logic [DATA_BITS-1:0] head;
  assign level       = wr_ptr - rd_ptr;
  assign empty       = level == '0;
  assign full        = level == PW'(DEPTH);
  assign almost_full = level >= PW'(AF_LEVEL);
  assign in_ready    = !full && !flush;
  // Empty forces 0 so uninitialised memory never reaches the transmitter.
  assign head        = empty ? '0 : mem[rd_ptr[AW-1:0]];
`ifdef UART_TX_FIFO_BYPASS_EN
  logic bypass;
  // Forwarded character is delivered this cycle, so neither pointer moves.
  assign bypass    = empty && in_valid && out_ready && !flush;
  assign out_valid = !empty || bypass;
  assign out_data  = bypass ? in_data : head;
  assign wr_en     = in_valid && in_ready && !bypass;
  assign rd_en     = out_valid && out_ready && !bypass;
`else
  assign out_valid = !empty;
  assign out_data  = head;
  assign wr_en     = in_valid && in_ready;
  assign rd_en     = out_valid && out_ready;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
    end
  // Storage is never cleared; reset and flush only move the pointers.
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_data;
endmodule
